// File: rtl/dm_pkg.sv
// Shared encodings and byte-lane helpers for the dm_sub data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Little-endian lane enables: lane 0 is bits [7:0].
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Drops the low address bits that a half or word access cannot use.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] res;
    case (size)
      SZ_BYTE: res = lo;
      SZ_HALF: res = {lo[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_align.sv
// Combinational lane steering: store replication/byte enables and load
// lane select with sign or zero extension.
module dm_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] din,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be = byte_en(size, lo);
    case (size)
      SZ_BYTE: wdata = {4{din[7:0]}};
      SZ_HALF: wdata = {2{din[15:0]}};
      default: wdata = din;
    endcase
  end

  always_comb begin
    case (lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{~uns & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{~uns & half_v[15]}}, half_v};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/dm_sub.sv
// Byte/half/word data memory with clear-on-reset and one-cycle registered
// response. Misalignment trapping is enabled by defining DM_MISALIGN_TRAP_EN.
//   state    | meaning
//   ST_CLEAR | zeroing one word per cycle, ready low
//   ST_RUN   | accepting one request per cycle
module dm_sub
  import dm_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              ready,
  output logic              ack,
  output logic [31:0]       dout,
  output logic              fault
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 1 << IDX_W;

  logic [31:0] mem_q [WORDS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ack_q, ack_d;
  logic             fault_q, fault_d;
  logic [31:0]      dout_q, dout_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       size_eff;
  logic [1:0]       lo_eff;
  logic             bad;
  logic [31:0]      rdata;
  logic [31:0]      st_wdata;
  logic [3:0]       st_be;
  logic [31:0]      ld_data;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;

  assign idx   = addr[ADDR_W-1:2];
  assign rdata = mem_q[idx];

  always_comb begin
`ifdef DM_MISALIGN_TRAP_EN
    bad      = is_misaligned(size, addr[1:0]);
    size_eff = size;
    lo_eff   = addr[1:0];
`else
    bad      = 1'b0;
    size_eff = (size == SZ_ILL) ? SZ_WORD : size;
    lo_eff   = force_align(size_eff, addr[1:0]);
`endif
  end

  dm_align u_align (
    .size    (size_eff),
    .uns     (uns),
    .lo      (lo_eff),
    .din     (din),
    .rdata   (rdata),
    .wdata   (st_wdata),
    .be      (st_be),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ack_d     = 1'b0;
    fault_d   = 1'b0;
    dout_d    = 32'h0;
    mem_we    = 1'b0;
    mem_widx  = idx;
    mem_wdata = st_wdata;
    mem_be    = st_be;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_cnt_q;
        mem_wdata = 32'h0;
        mem_be    = 4'b1111;
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == {IDX_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (req) begin
          ack_d   = 1'b1;
          fault_d = bad;
          if (we) begin
            mem_we = ~bad;
          end else if (!bad) begin
            dout_d = ld_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ack_q     <= 1'b0;
      fault_q   <= 1'b0;
      dout_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ack_q     <= ack_d;
      fault_q   <= fault_d;
      dout_q    <= dout_d;
    end
  end

  // Storage has no reset of its own; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ready = (state_q == ST_RUN);
  assign ack   = ack_q;
  assign dout  = dout_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_dm_sub.sv
// Self-checking bench for dm_sub (ADDR_W = 6) using an expected-response queue.
module tb_dm_sub;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          uns;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic          ready;
  logic          ack;
  logic [31:0]   dout;
  logic          fault;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_fault;
  } op_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  dm_sub #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .size  (size),
    .uns   (uns),
    .addr  (addr),
    .din   (din),
    .ready (ready),
    .ack   (ack),
    .dout  (dout),
    .fault (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic op_t mk(input logic w, input logic [1:0] sz, input logic u,
                             input logic [5:0] a, input logic [31:0] d,
                             input logic [31:0] ed, input logic ef);
    op_t o;
    o.we = w; o.size = sz; o.uns = u; o.addr = a; o.din = d;
    o.exp_dout = ed; o.exp_fault = ef;
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    exp_t e;
    req = 1'b1; we = o.we; size = o.size; uns = o.uns; addr = o.addr; din = o.din;
    e.dout = o.exp_dout; e.fault = o.exp_fault;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; din = 32'h0;
  endtask

  // Holds req through the clear and counts edges until ready rises.
  task automatic wait_clear(input string tag);
    int n = 0;
    bit spurious = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 6'h10;
    rst = 1'b0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ack !== 1'b0) spurious = 1;
    end
    idle();
    checks++;
    if (n != 16) begin
      failures++; $display("FAIL %s_clear_cycles got=%0d exp=16", tag, n);
    end
    checks++;
    if (spurious) begin
      failures++; $display("FAIL %s_ack_during_clear got=1 exp=0", tag);
    end
  endtask

  task automatic run_ops(input string tag, input op_t ops[$]);
    exp_t e;
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ack !== 1'b1) begin
          failures++; $display("FAIL %s_ack[%0d] got=%b exp=1", tag, i, ack);
        end else begin
          checks++;
          if (dout !== e.dout) begin
            failures++; $display("FAIL %s_dout[%0d] got=%h exp=%h", tag, i, dout, e.dout);
          end
          checks++;
          if (fault !== e.fault) begin
            failures++; $display("FAIL %s_fault[%0d] got=%b exp=%b", tag, i, fault, e.fault);
          end
        end
      end else begin
        checks++;
        if (ack !== 1'b0) begin
          failures++; $display("FAIL %s_idle_ack[%0d] got=%b exp=0", tag, i, ack);
        end
      end
      if (i < ops.size()) drive_op(ops[i]);
      else idle();
    end
  endtask

  task automatic test_reset();
    op_t ops[$];
    #22;
    checks++;
    if ({ready, ack, fault} !== 3'b000 || dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b/%h exp=000/00000000", ready, ack, fault, dout);
    end
    wait_clear("reset");
    ops.push_back(mk(0, 2'b10, 0, 6'h3C, 32'h0, 32'h0000_0000, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h00, 32'h0, 32'h0000_0000, 0));
    run_ops("reset_load", ops);
  endtask

  task automatic test_byte();
    op_t ops[$];
    ops.push_back(mk(1, 2'b10, 0, 6'h10, 32'h1122_3344, 32'h0, 0));
    ops.push_back(mk(1, 2'b00, 0, 6'h12, 32'h0000_00AB, 32'h0, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h10, 32'h0, 32'h11AB_3344, 0));
    ops.push_back(mk(0, 2'b00, 0, 6'h12, 32'h0, 32'hFFFF_FFAB, 0));
    ops.push_back(mk(0, 2'b00, 1, 6'h12, 32'h0, 32'h0000_00AB, 0));
    ops.push_back(mk(0, 2'b00, 0, 6'h13, 32'h0, 32'h0000_0011, 0));
    run_ops("byte", ops);
  endtask

  task automatic test_half();
    op_t ops[$];
    ops.push_back(mk(1, 2'b01, 0, 6'h16, 32'hFFFF_8001, 32'h0, 0));
    ops.push_back(mk(0, 2'b01, 0, 6'h16, 32'h0, 32'hFFFF_8001, 0));
    ops.push_back(mk(0, 2'b01, 1, 6'h16, 32'h0, 32'h0000_8001, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h14, 32'h0, 32'h8001_0000, 0));
    run_ops("half", ops);
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    ops.push_back(mk(1, 2'b10, 0, 6'h08, 32'hCAFE_F00D, 32'h0, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h08, 32'h0, 32'hCAFE_F00D, 0));
    ops.push_back(mk(1, 2'b00, 0, 6'h0B, 32'h1234_565A, 32'h0, 0));
    ops.push_back(mk(0, 2'b00, 0, 6'h0B, 32'h0, 32'h0000_005A, 0));
    ops.push_back(mk(0, 2'b01, 0, 6'h0A, 32'h0, 32'h0000_5AFE, 0));
    ops.push_back(mk(0, 2'b00, 0, 6'h08, 32'h0, 32'h0000_000D, 0));
    run_ops("b2b", ops);
  endtask

  task automatic test_misalign();
    op_t ops[$];
    ops.push_back(mk(1, 2'b10, 0, 6'h20, 32'h0102_0304, 32'h0, 0));
`ifdef DM_MISALIGN_TRAP_EN
    ops.push_back(mk(1, 2'b10, 0, 6'h21, 32'hDEAD_BEEF, 32'h0, 1));
    ops.push_back(mk(0, 2'b10, 0, 6'h20, 32'h0, 32'h0102_0304, 0));
    ops.push_back(mk(0, 2'b01, 1, 6'h23, 32'h0, 32'h0, 1));
    ops.push_back(mk(0, 2'b11, 0, 6'h20, 32'h0, 32'h0, 1));
`else
    ops.push_back(mk(1, 2'b10, 0, 6'h21, 32'hDEAD_BEEF, 32'h0, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h20, 32'h0, 32'hDEAD_BEEF, 0));
    ops.push_back(mk(0, 2'b01, 1, 6'h23, 32'h0, 32'h0000_DEAD, 0));
    ops.push_back(mk(0, 2'b11, 0, 6'h21, 32'h0, 32'hDEAD_BEEF, 0));
`endif
    run_ops("misalign", ops);
  endtask

  task automatic test_reset_mid_access();
    op_t ops[$];
    bit  spurious = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 6'h10; din = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (ready !== 1'b0 || ack !== 1'b0 || dout !== 32'h0) begin
      failures++;
      $display("FAIL midrst_immediate got=ready%b ack%b dout%h exp=ready0 ack0 dout00000000",
               ready, ack, dout);
    end
    repeat (3) begin
      @(negedge clk);
      if (ack !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin
      failures++; $display("FAIL midrst_ack_in_reset got=1 exp=0");
    end
    wait_clear("midrst");
    ops.push_back(mk(0, 2'b10, 0, 6'h10, 32'h0, 32'h0000_0000, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h08, 32'h0, 32'h0000_0000, 0));
    ops.push_back(mk(0, 2'b10, 0, 6'h3C, 32'h0, 32'h0000_0000, 0));
    run_ops("midrst_load", ops);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_byte();
    test_half();
    test_back_to_back();
    test_misalign();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
